wb_mem_responder: RTL and testbench
===================================

WB_MEM_RESPONDER -- requirements
Module: wb_mem_responder

Interface
REQ-001 Parameter LINES, default 256: number of 128-bit lines in the backing store; power of two, 2..4096.
REQ-002 Parameter LATENCY, default 3: cycles from request acceptance to ACK; integer 1..15.
REQ-003 Clocking and reset SHALL be one clock and an asynchronous, active-low reset.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 CYC  input  1  wishbone cycle valid from the master.
REQ-007 STB  input  1  wishbone strobe from the master.
REQ-008 WE  input  1  1 = write, 0 = read.
REQ-009 ADR  input  12  line address (byte address bits [15:4]).
REQ-010 SEL  input  16  byte enables; bit i selects byte lane [8i+7:8i].
REQ-011 DAT_M  input  128  write data.
REQ-012 DAT_S  output  128  read data.
REQ-013 ACK  output  1  single-cycle transaction acknowledge.
REQ-014 cnt_clr  input  1  synchronous clear of both counters.
REQ-015 read_count  output  16  completed reads.
REQ-016 write_count  output  16  completed writes.

Function
REQ-017 FSM states SHALL be IDLE, WAIT and RESP.
REQ-018 In IDLE with CYC&STB=1 at a rising edge, the block SHALL latch ADR, WE, SEL and DAT_M, load the latency counter with LATENCY-1, and enter WAIT; if LATENCY=1, it SHALL enter RESP directly instead.
REQ-019 In WAIT the counter SHALL decrement each cycle; the block SHALL enter RESP at the edge where the counter equals 1, so ACK is high exactly LATENCY cycles after the accepting edge.
REQ-020 ACK SHALL be 1 only in RESP, for exactly one cycle; RESP SHALL always return to IDLE.
REQ-021 Consecutive requests SHALL therefore be separated by at least one IDLE cycle; a request held on CYC&STB through RESP SHALL be re-accepted in the following IDLE cycle.
REQ-022 Line index SHALL be the latched ADR[log2(LINES)-1:0]; upper ADR bits SHALL be ignored (aliasing).
REQ-023 A write SHALL update only the SEL-enabled byte lanes of the indexed line, at the edge entering RESP.
REQ-024 A write with SEL=0 SHALL be acknowledged and counted with no storage change.
REQ-025 A read SHALL drive DAT_S during RESP with the indexed line as of the edge entering RESP, reflecting all earlier writes.
REQ-026 DAT_S SHALL be all zeros whenever ACK=0.
REQ-027 If CYC=0 at any edge while in WAIT, the transaction SHALL abort: return to IDLE, no write, no ACK, no count.
REQ-028 STB deasserting in WAIT while CYC=1 SHALL NOT abort the transaction.
REQ-029 read_count and write_count SHALL increment by 1, wrapping 0xFFFF to 0x0000, at the edge leaving RESP for a read or write respectively.
REQ-030 cnt_clr SHALL zero both counters and SHALL take priority over a same-cycle increment.
REQ-031 In IDLE, inputs other than CYC and STB SHALL be ignored; in WAIT and RESP, all input changes except CYC in WAIT SHALL be ignored.

Reset
REQ-032 On rst_n=0 the block SHALL immediately enter IDLE and force ACK=0, DAT_S=0, read_count=0 and write_count=0.
REQ-033 Reset SHALL NOT alter storage contents.
REQ-034 Reset asserted during WAIT or RESP SHALL cancel the transaction with no write and no count.
REQ-035 The first request SHALL be accepted at the first rising edge after rst_n deasserts.

Verification
REQ-036 Latency: LATENCY=3, write ADR=0x005, SEL=0xFFFF, DAT_M=0x0123..EF, then read ADR=0x005 -> each ACK exactly 3 cycles after acceptance; read DAT_S matches the written line; write_count=1, read_count=1.
REQ-037 Byte lanes: line 0x005 holds all-0xAA; write SEL=0x0003, DAT_M low 16 bits 0x1234 -> readback has bytes 1:0 = 0x1234 and all other bytes 0xAA.
REQ-038 Abort: drop CYC in the second WAIT cycle of a write -> no ACK, line unchanged, write_count unchanged; the next request is accepted normally.
REQ-039 Back-to-back with LATENCY=1 and STB held high -> ACK pattern 1,0,1,0; reads return successive line data.
REQ-040 Counters: preload read_count to 0xFFFF via 65535 reads, one more read -> 0x0000; cnt_clr asserted in a RESP cycle -> both counters 0.
REQ-041 Reset mid-WAIT on a write -> ACK stays 0, line unchanged, counters 0; data written before reset is still readable afterwards.

Source files
------------

// File: rtl/wb_mem_if.sv
// wb_mem_if: wishbone-style request/response bundle between a master and the line-store responder
interface wb_mem_if;
  logic         CYC;
  logic         STB;
  logic         WE;
  logic [11:0]  ADR;
  logic [15:0]  SEL;
  logic [127:0] DAT_M;
  logic [127:0] DAT_S;
  logic         ACK;
  modport master (output CYC, STB, WE, ADR, SEL, DAT_M, input DAT_S, ACK);
  modport slave (input CYC, STB, WE, ADR, SEL, DAT_M, output DAT_S, ACK);
endinterface

// File: rtl/wb_mem_responder.sv
// wb_mem_responder: wishbone slave over a 128-bit line store with byte-lane writes and a fixed
// accept-to-ACK latency, plus wrapping read/write completion counters
module wb_mem_responder #(
  parameter int LINES   = 256,
  parameter int LATENCY = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  wb_mem_if.slave     bus,
  input  logic        cnt_clr,
  output logic [15:0] read_count,
  output logic [15:0] write_count
);
  localparam int AW = $clog2(LINES);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic           we_q, we_d;
  logic [AW-1:0]  idx_q, idx_d;
  logic [15:0]    sel_q, sel_d;
  logic [127:0]   dat_q, dat_d;
  logic           ack_q, ack_d;
  logic [127:0]   rdat_q, rdat_d;
  logic [15:0]    rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
  logic           accept, enter_resp, we_e;
  logic [AW-1:0]  idx_e;
  logic [15:0]    sel_e;
  logic [127:0]   dat_e;
  logic [127:0]   mem [LINES];
  // the *_e view is the live bus on the accepting edge, so LATENCY=1 can complete on that same edge
  always_comb begin
    accept     = state_q == IDLE && bus.CYC && bus.STB;
    enter_resp = accept ? (LATENCY == 1) : (state_q == WAIT && bus.CYC && cnt_q == 4'd1);
    we_e       = accept ? bus.WE : we_q;
    idx_e      = accept ? AW'(bus.ADR) : idx_q;
    sel_e      = accept ? bus.SEL : sel_q;
    dat_e      = accept ? bus.DAT_M : dat_q;
    we_d       = we_e;
    idx_d      = idx_e;
    sel_d      = sel_e;
    dat_d      = dat_e;
    state_d    = enter_resp ? RESP : (accept || (state_q == WAIT && bus.CYC)) ? WAIT : IDLE;
    cnt_d      = accept ? 4'(LATENCY - 1) : state_q == WAIT ? cnt_q - 4'd1 : cnt_q;
    ack_d      = enter_resp;
    rdat_d     = (enter_resp && !we_e) ? mem[idx_e] : '0;
    rd_cnt_d   = cnt_clr ? '0 : rd_cnt_q + 16'(state_q == RESP && !we_q);
    wr_cnt_d   = cnt_clr ? '0 : wr_cnt_q + 16'(state_q == RESP && we_q);
  end
  // storage sits outside the reset branch so its contents survive reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      idx_q    <= '0;
      sel_q    <= '0;
      dat_q    <= '0;
      ack_q    <= 1'b0;
      rdat_q   <= '0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      idx_q    <= idx_d;
      sel_q    <= sel_d;
      dat_q    <= dat_d;
      ack_q    <= ack_d;
      rdat_q   <= rdat_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
      if (enter_resp && we_e)
        for (int i = 0; i < 16; i++)
          if (sel_e[i]) mem[idx_e][8*i +: 8] <= dat_e[8*i +: 8];
    end
  end
  assign bus.ACK     = ack_q;
  assign bus.DAT_S   = rdat_q;
  assign read_count  = rd_cnt_q;
  assign write_count = wr_cnt_q;
endmodule

// File: tb/tb_wb_mem_responder.sv
// tb_wb_mem_responder: randomized and directed checks of two responder instances (LATENCY 3 / 256 lines,
// LATENCY 1 / 16 lines) sharing one bus driver, against a line-array reference model
module tb_wb_mem_responder;
  logic clk = 0, rst_n = 0, cyc = 0, stb = 0, we_i = 0, clr = 0, use_b = 0;
  logic [11:0] adr_i = '0;
  logic [15:0] sel_i = '0;
  logic [127:0] dat_i = '0;
  logic ack, clr_a, clr_b;
  logic [127:0] dat_s;
  logic [15:0] rc, wc, rc_a, wc_a, rc_b, wc_b;
  int errors = 0, checks = 0;
  logic [127:0] ma [256];
  logic [127:0] mb [16];
  logic [15:0] rca = 0, wca = 0, rcb = 0, wcb = 0;

  wb_mem_if ifa ();
  wb_mem_if ifb ();
  assign ifa.CYC = cyc & ~use_b;
  assign ifb.CYC = cyc & use_b;
  assign ifa.STB = stb;
  assign ifb.STB = stb;
  assign ifa.WE = we_i;
  assign ifb.WE = we_i;
  assign ifa.ADR = adr_i;
  assign ifb.ADR = adr_i;
  assign ifa.SEL = sel_i;
  assign ifb.SEL = sel_i;
  assign ifa.DAT_M = dat_i;
  assign ifb.DAT_M = dat_i;
  assign clr_a = clr & ~use_b;
  assign clr_b = clr & use_b;
  assign ack = use_b ? ifb.ACK : ifa.ACK;
  assign dat_s = use_b ? ifb.DAT_S : ifa.DAT_S;
  assign rc = use_b ? rc_b : rc_a;
  assign wc = use_b ? wc_b : wc_a;

  wb_mem_responder #(.LINES(256), .LATENCY(3)) u_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa), .cnt_clr(clr_a), .read_count(rc_a), .write_count(wc_a));
  wb_mem_responder #(.LINES(16), .LATENCY(1)) u_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb), .cnt_clr(clr_b), .read_count(rc_b), .write_count(wc_b));

  always #5 clk = ~clk;

  initial begin
    #4000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // reference: a line is an array slot, a write merges enabled bytes, a read returns the slot
  task automatic model_txn(input bit b, input bit we, input logic [11:0] adr, input logic [15:0] sel,
                           input logic [127:0] dat, output logic [127:0] exp);
    int idx;
    logic [127:0] line;
    idx = b ? int'(adr) % 16 : int'(adr) % 256;
    line = b ? mb[idx] : ma[idx];
    exp = we ? '0 : line;
    if (we) for (int i = 0; i < 16; i++) if (sel[i]) line[8*i +: 8] = dat[8*i +: 8];
    if (b) begin
      mb[idx] = line;
      if (we) wcb = wcb + 16'd1; else rcb = rcb + 16'd1;
    end else begin
      ma[idx] = line;
      if (we) wca = wca + 16'd1; else rca = rca + 16'd1;
    end
  endtask

  task automatic run_txn(input bit b, input bit we, input logic [11:0] adr, input logic [15:0] sel,
                         input logic [127:0] dat, input bit noise,
                         output logic [127:0] rd, output int lat, output bit leak);
    use_b = b;
    @(negedge clk);
    cyc = 1; stb = 1; we_i = we; adr_i = adr; sel_i = sel; dat_i = dat;
    lat = 0; leak = 0; rd = '0;
    do begin
      @(negedge clk);
      lat++;
      if (!ack && dat_s !== '0) leak = 1;
      if (noise && !ack) begin
        stb = 1'($urandom); we_i = 1'($urandom); adr_i = 12'($urandom);
        sel_i = 16'($urandom); dat_i = rnd128();
      end
    end while (ack !== 1'b1 && lat < 40);
    rd = dat_s;
    cyc = 0; stb = 0;
    @(negedge clk);
    if (ack !== 1'b0 || dat_s !== '0) leak = 1;
  endtask

  task automatic clear_counters(input bit b);
    use_b = b;
    @(negedge clk); clr = 1;
    @(negedge clk); clr = 0;
    if (b) begin rcb = 0; wcb = 0; end else begin rca = 0; wca = 0; end
  endtask

  task automatic release_reset();
    @(posedge clk); #1 rst_n = 1;
  endtask

  task automatic test_reset();
    logic [127:0] rd, exp;
    int lat;
    bit leak;
    repeat (3) @(negedge clk);
    for (int b = 0; b < 2; b++) begin
      use_b = 1'(b); #1;
      checks++; if (ack !== 1'b0) begin errors++; $display("FAIL reset_ack dut%0d got=%b exp=0", b, ack); end
      checks++; if (dat_s !== '0) begin errors++; $display("FAIL reset_dat dut%0d got=%h exp=0", b, dat_s); end
      checks++; if (rc !== 16'h0) begin errors++; $display("FAIL reset_rc dut%0d got=%h exp=0", b, rc); end
      checks++; if (wc !== 16'h0) begin errors++; $display("FAIL reset_wc dut%0d got=%h exp=0", b, wc); end
    end
    release_reset();
    run_txn(0, 1, 12'h00F, 16'hFFFF, 128'hFEED, 0, rd, lat, leak);
    model_txn(0, 1, 12'h00F, 16'hFFFF, 128'hFEED, exp);
    checks++; if (lat != 3) begin errors++; $display("FAIL first_accept lat got=%0d exp=3", lat); end
  endtask

  task automatic fill_all();
    logic [127:0] rd, exp, d;
    int lat;
    bit leak;
    for (int i = 0; i < 256; i++) begin
      d = rnd128();
      run_txn(0, 1, 12'(i), 16'hFFFF, d, 0, rd, lat, leak);
      model_txn(0, 1, 12'(i), 16'hFFFF, d, exp);
    end
    for (int i = 0; i < 16; i++) begin
      d = rnd128();
      run_txn(1, 1, 12'(i), 16'hFFFF, d, 0, rd, lat, leak);
      model_txn(1, 1, 12'(i), 16'hFFFF, d, exp);
    end
  endtask

  task automatic test_latency();
    logic [127:0] rd, exp, d;
    int lat;
    bit leak;
    d = 128'h0123456789ABCDEF0123456789ABCDEF;
    clear_counters(0);
    run_txn(0, 1, 12'h005, 16'hFFFF, d, 0, rd, lat, leak);
    model_txn(0, 1, 12'h005, 16'hFFFF, d, exp);
    checks++; if (lat != 3) begin errors++; $display("FAIL lat_write got=%0d exp=3", lat); end
    checks++; if (leak) begin errors++; $display("FAIL lat_write_idle got=1 exp=0"); end
    run_txn(0, 0, 12'h005, 16'h0, '0, 0, rd, lat, leak);
    model_txn(0, 0, 12'h005, 16'h0, '0, exp);
    checks++; if (lat != 3) begin errors++; $display("FAIL lat_read got=%0d exp=3", lat); end
    checks++; if (rd !== d) begin errors++; $display("FAIL lat_read_data got=%h exp=%h", rd, d); end
    checks++; if (wc !== 16'd1) begin errors++; $display("FAIL lat_wc got=%0d exp=1", wc); end
    checks++; if (rc !== 16'd1) begin errors++; $display("FAIL lat_rc got=%0d exp=1", rc); end
  endtask

  task automatic test_byte_lanes();
    logic [127:0] rd, exp, want, d;
    int lat;
    bit leak;
    want = {{14{8'hAA}}, 16'h1234};
    run_txn(0, 1, 12'h005, 16'hFFFF, {16{8'hAA}}, 0, rd, lat, leak);
    model_txn(0, 1, 12'h005, 16'hFFFF, {16{8'hAA}}, exp);
    d = {rnd128() >> 16, 16'h1234};
    run_txn(0, 1, 12'h005, 16'h0003, d, 0, rd, lat, leak);
    model_txn(0, 1, 12'h005, 16'h0003, d, exp);
    run_txn(0, 0, 12'h005, 16'h0, '0, 0, rd, lat, leak);
    model_txn(0, 0, 12'h005, 16'h0, '0, exp);
    checks++; if (rd !== want) begin errors++; $display("FAIL lanes_data got=%h exp=%h", rd, want); end
    run_txn(0, 1, 12'h005, 16'h0000, rnd128(), 0, rd, lat, leak);
    model_txn(0, 1, 12'h005, 16'h0000, '0, exp);
    checks++; if (lat != 3) begin errors++; $display("FAIL sel0_ack lat got=%0d exp=3", lat); end
    checks++; if (wc !== wca) begin errors++; $display("FAIL sel0_wc got=%0d exp=%0d", wc, wca); end
    run_txn(0, 0, 12'h005, 16'h0, '0, 0, rd, lat, leak);
    model_txn(0, 0, 12'h005, 16'h0, '0, exp);
    checks++; if (rd !== want) begin errors++; $display("FAIL sel0_data got=%h exp=%h", rd, want); end
  endtask

  task automatic test_abort();
    logic [127:0] rd, exp;
    int lat;
    bit leak, seen;
    use_b = 0;
    @(negedge clk);
    cyc = 1; stb = 1; we_i = 1; adr_i = 12'h033; sel_i = 16'hFFFF; dat_i = ~ma[8'h33];
    @(negedge clk);
    @(negedge clk);
    cyc = 0; stb = 0;
    seen = 0;
    repeat (5) begin @(negedge clk); if (ack !== 1'b0) seen = 1; end
    checks++; if (seen) begin errors++; $display("FAIL abort_ack got=1 exp=0"); end
    checks++; if (wc !== wca) begin errors++; $display("FAIL abort_wc got=%0d exp=%0d", wc, wca); end
    run_txn(0, 0, 12'h033, 16'h0, '0, 0, rd, lat, leak);
    model_txn(0, 0, 12'h033, 16'h0, '0, exp);
    checks++; if (lat != 3) begin errors++; $display("FAIL abort_next_lat got=%0d exp=3", lat); end
    checks++; if (rd !== exp) begin errors++; $display("FAIL abort_line got=%h exp=%h", rd, exp); end
  endtask

  task automatic test_back_to_back();
    logic [11:0] a [4];
    logic [127:0] exp;
    for (int i = 0; i < 4; i++) a[i] = {8'($urandom), 4'(i)};
    use_b = 1;
    @(negedge clk);
    cyc = 1; stb = 1; we_i = 0; sel_i = '0; adr_i = a[0];
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checks++;
      if (ack !== (k % 2 == 0)) begin errors++; $display("FAIL b2b_ack[%0d] got=%b exp=%b", k, ack, k % 2 == 0); end
      if (k % 2 == 0) begin
        model_txn(1, 0, a[k/2], 16'h0, '0, exp);
        checks++; if (dat_s !== exp) begin errors++; $display("FAIL b2b_data[%0d] got=%h exp=%h", k/2, dat_s, exp); end
        if (k < 6) adr_i = a[k/2 + 1];
      end else if (k == 7) begin
        cyc = 0; stb = 0;
      end
    end
    @(negedge clk);
    checks++; if (rc !== rcb) begin errors++; $display("FAIL b2b_rc got=%0d exp=%0d", rc, rcb); end
  endtask

  task automatic test_counters();
    logic [127:0] rd, exp, d;
    int lat, n, cycles;
    bit leak;
    clear_counters(1);
    @(negedge clk);
    cyc = 1; stb = 1; we_i = 0; adr_i = 12'h003;
    n = 0; cycles = 0;
    while (n < 65535 && cycles < 140000) begin
      @(negedge clk); cycles++;
      if (ack) n++;
    end
    cyc = 0; stb = 0;
    rcb = rcb + 16'(n);
    checks++; if (n != 65535) begin errors++; $display("FAIL cnt_preload acks got=%0d exp=65535", n); end
    @(negedge clk);
    checks++; if (rc !== 16'hFFFF) begin errors++; $display("FAIL cnt_ffff got=%h exp=ffff", rc); end
    run_txn(1, 0, 12'h003, 16'h0, '0, 0, rd, lat, leak);
    model_txn(1, 0, 12'h003, 16'h0, '0, exp);
    checks++; if (rc !== 16'h0000) begin errors++; $display("FAIL cnt_wrap got=%h exp=0000", rc); end
    checks++; if (rd !== exp) begin errors++; $display("FAIL cnt_wrap_data got=%h exp=%h", rd, exp); end
    run_txn(1, 0, 12'h004, 16'h0, '0, 0, rd, lat, leak);
    model_txn(1, 0, 12'h004, 16'h0, '0, exp);
    d = rnd128();
    @(negedge clk);
    cyc = 1; stb = 1; we_i = 1; adr_i = 12'h007; sel_i = 16'hFFFF; dat_i = d;
    @(negedge clk);
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL clr_resp_ack got=%b exp=1", ack); end
    clr = 1;
    @(negedge clk);
    clr = 0; cyc = 0; stb = 0;
    model_txn(1, 1, 12'h007, 16'hFFFF, d, exp);
    rcb = 0; wcb = 0;
    checks++; if (rc !== 16'h0 || wc !== 16'h0) begin errors++; $display("FAIL clr_priority got=%h/%h exp=0/0", rc, wc); end
  endtask

  task automatic test_random();
    logic [127:0] rd, exp, dat;
    logic [15:0] sel;
    logic [11:0] adr;
    bit b, we, noise, leak;
    int lat;
    for (int n = 0; n < 300; n++) begin
      b = 1'($urandom); we = 1'($urandom); adr = 12'($urandom); sel = 16'($urandom);
      if (n % 7 == 0) sel = 16'h0000;
      if (n % 5 == 0) sel = 16'hFFFF;
      dat = rnd128(); noise = 1'($urandom);
      run_txn(b, we, adr, sel, dat, noise, rd, lat, leak);
      model_txn(b, we, adr, sel, dat, exp);
      checks++; if (lat != (b ? 1 : 3)) begin errors++; $display("FAIL rnd_lat[%0d] got=%0d exp=%0d", n, lat, b ? 1 : 3); end
      checks++; if (leak) begin errors++; $display("FAIL rnd_idle_out[%0d] got=1 exp=0", n); end
      if (!we) begin
        checks++; if (rd !== exp) begin errors++; $display("FAIL rnd_data[%0d] got=%h exp=%h", n, rd, exp); end
      end
      checks++;
      if (rc !== (b ? rcb : rca) || wc !== (b ? wcb : wca)) begin
        errors++; $display("FAIL rnd_cnt[%0d] got=%h/%h exp=%h/%h", n, rc, wc, b ? rcb : rca, b ? wcb : wca);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [127:0] rd, exp;
    int lat;
    bit leak;
    use_b = 0;
    @(negedge clk);
    cyc = 1; stb = 1; we_i = 1; adr_i = 12'h0AA; sel_i = 16'hFFFF; dat_i = ~ma[8'hAA];
    @(negedge clk);
    rst_n = 0;
    #1;
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL rstmid_ack got=%b exp=0", ack); end
    checks++; if (rc !== 16'h0 || wc !== 16'h0) begin errors++; $display("FAIL rstmid_cnt got=%h/%h exp=0/0", rc, wc); end
    rca = 0; wca = 0; rcb = 0; wcb = 0;
    cyc = 0; stb = 0;
    repeat (2) @(negedge clk);
    release_reset();
    run_txn(0, 0, 12'h0AA, 16'h0, '0, 0, rd, lat, leak);
    model_txn(0, 0, 12'h0AA, 16'h0, '0, exp);
    checks++; if (rd !== exp) begin errors++; $display("FAIL rstmid_line got=%h exp=%h", rd, exp); end
    checks++; if (rc !== 16'd1 || wc !== 16'd0) begin errors++; $display("FAIL rstmid_after got=%h/%h exp=1/0", rc, wc); end
    run_txn(1, 0, 12'h002, 16'h0, '0, 0, rd, lat, leak);
    model_txn(1, 0, 12'h002, 16'h0, '0, exp);
    checks++; if (rd !== exp) begin errors++; $display("FAIL rstmid_keep_b got=%h exp=%h", rd, exp); end
  endtask

  initial begin
    test_reset();
    fill_all();
    test_latency();
    test_byte_lanes();
    test_abort();
    test_back_to_back();
    test_random();
    test_counters();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
